// File: rtl/mov_sequencer_if.sv
// mov_sequencer_if: bus between a node's MOV sequencer and its port I/O block (nodeio).
//
// Signals:
//   direction    sequencer -> nodeio  port selected for this handshake (UP/DOWN/LEFT/RIGHT/ANY/LAST)
//   tx           sequencer -> nodeio  transmit request
//   rx           sequencer -> nodeio  receive request
//   out_data     sequencer -> nodeio  word to transmit
//   in_data      nodeio -> sequencer  received word
//   tx_complete  nodeio -> sequencer  transmit handshake finished this cycle
//   rx_complete  nodeio -> sequencer  receive handshake finished this cycle
//
// Modports: master = sequencer side, slave = nodeio side.

interface mov_sequencer_if #(
    parameter int unsigned WordWidth = 16
);
    logic [2:0]           direction;
    logic                 tx;
    logic                 rx;
    logic [WordWidth-1:0] out_data;
    logic [WordWidth-1:0] in_data;
    logic                 tx_complete;
    logic                 rx_complete;

    modport master (
        output direction, tx, rx, out_data,
        input  in_data, tx_complete, rx_complete
    );

    modport slave (
        input  direction, tx, rx, out_data,
        output in_data, tx_complete, rx_complete
    );
endinterface

// File: rtl/mov_sequencer.sv
// mov_sequencer: sequences a node's port I/O block for MOV instructions that touch a port.
// Accepts one decoded transfer (receive-then-transmit, receive only, transmit only, or
// register pass-through), drives the nodeio handshakes and stalls the core until done.
//
// Ports:
//   CLK, nRST      clock; synchronous active-low reset
//   start          one-cycle issue strobe, honoured only in IDLE
//   src_port       source operand is a port; src_dir its direction
//   src_value      source value when the source is not a port
//   dst_port       destination operand is a port; dst_dir its direction
//   busy           core stall
//   done           one-cycle completion pulse; result valid with it
//   result_we      register write-back strobe (done and destination is not a port)
//   watchdog       sticky stall flag (only when MOVSEQ_WATCHDOG_EN is defined)
//   io             master side of mov_sequencer_if towards nodeio
//
// Optional build macro: MOVSEQ_WATCHDOG_EN adds an 11-bit stall counter and the watchdog
// output, flagging a handshake that has stalled for WATCHDOG_CYCLES cycles.
//
// Direction encoding: UP=0, DOWN=1, LEFT=2, RIGHT=3, ANY=4, LAST=5. ANY/LAST are passed
// through unresolved; nodeio resolves them.

module mov_sequencer #(
    parameter int unsigned WATCHDOG_CYCLES = 1023
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 start,
    input  logic                 src_port,
    input  logic [2:0]           src_dir,
    input  logic [15:0]          src_value,
    input  logic                 dst_port,
    input  logic [2:0]           dst_dir,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          result,
    output logic                 result_we,
`ifdef MOVSEQ_WATCHDOG_EN
    output logic                 watchdog,
`endif
    mov_sequencer_if.master      io
);

    localparam logic [2:0] DirUp = 3'd0;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRx   = 2'd1;
    localparam logic [1:0] StTx   = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [15:0] data_q, data_d;
    logic [2:0]  src_dir_q, src_dir_d;
    logic [2:0]  dst_dir_q, dst_dir_d;
    logic        dst_port_q, dst_port_d;
    logic        accept;

    assign accept = (state_q == StIdle) && start;

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        src_dir_d  = src_dir_q;
        dst_dir_d  = dst_dir_q;
        dst_port_d = dst_port_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    src_dir_d  = src_dir;
                    dst_dir_d  = dst_dir;
                    dst_port_d = dst_port;
                    if (!src_port) begin
                        data_d = src_value;
                    end
                    if (src_port) begin
                        state_d = StRx;
                    end else if (dst_port) begin
                        state_d = StTx;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StRx: begin
                if (io.rx_complete) begin
                    data_d  = io.in_data;
                    state_d = dst_port_q ? StTx : StDone;
                end
            end
            StTx: begin
                if (io.tx_complete) begin
                    state_d = StDone;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q    <= StIdle;
            data_q     <= '0;
            src_dir_q  <= '0;
            dst_dir_q  <= '0;
            dst_port_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            src_dir_q  <= src_dir_d;
            dst_dir_q  <= dst_dir_d;
            dst_port_q <= dst_port_d;
        end
    end

    always_comb begin
        busy        = accept || (state_q == StRx) || (state_q == StTx);
        done        = (state_q == StDone);
        result      = done ? data_q : '0;
        result_we   = done && !dst_port_q;
        io.rx       = (state_q == StRx);
        io.tx       = (state_q == StTx);
        io.out_data = data_q;
        if (state_q == StRx) begin
            io.direction = src_dir_q;
        end else if (state_q == StTx) begin
            io.direction = dst_dir_q;
        end else begin
            io.direction = DirUp;
        end
    end

`ifdef MOVSEQ_WATCHDOG_EN
    logic [10:0] wd_cnt_q, wd_cnt_d;
    logic        watchdog_q, watchdog_d;

    always_comb begin
        wd_cnt_d   = wd_cnt_q;
        watchdog_d = watchdog_q;
        if (state_d != state_q) begin
            wd_cnt_d = '0;
        end else if (((state_q == StRx) || (state_q == StTx)) && (wd_cnt_q != 11'h7ff)) begin
            wd_cnt_d = wd_cnt_q + 11'd1;
        end
        // An accepted start always clears the flag, even if the count also matches.
        if (accept) begin
            watchdog_d = 1'b0;
        end else if (wd_cnt_d == 11'(WATCHDOG_CYCLES)) begin
            watchdog_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wd_cnt_q   <= '0;
            watchdog_q <= 1'b0;
        end else begin
            wd_cnt_q   <= wd_cnt_d;
            watchdog_q <= watchdog_d;
        end
    end

    assign watchdog = watchdog_q;
`endif

endmodule

// File: doc/mov_sequencer.md
# mov_sequencer

Per-node controller that sequences the node's port I/O datapath (`nodeio`) for MOV instructions that touch a port. It accepts one decoded transfer from the node core, drives `direction`/`tx`/`rx`/`out_data` into the I/O block, and stalls the core until every handshake completes. Supported transfers are receive-then-transmit for port-to-port moves, single receive, and single transmit. It sits between the node's decode/execute stage and `nodeio`, and is instantiated once per node.

## Interface
- `WATCHDOG_CYCLES`, default 1023: stall-cycle threshold for the watchdog. Used only with `MOVSEQ_WATCHDOG_EN`.
- `CLK` in 1: clock; all state updates on posedge.
- `nRST` in 1: reset, synchronous, active-low; sampled on posedge `CLK`.
- `start` in 1: one-cycle issue strobe from the core; honoured only in IDLE.
- `src_port` in 1: source operand is a port.
- `src_dir` in `direction_t`: source direction (UP/DOWN/LEFT/RIGHT/ANY/LAST).
- `src_value` in `word_t`: source value when `src_port`=0 (register or immediate).
- `dst_port` in 1: destination operand is a port.
- `dst_dir` in `direction_t`: destination direction.
- `busy` out 1: core stall.
- `done` out 1: one-cycle completion pulse.
- `result` out `word_t`: moved value, valid with `done`.
- `result_we` out 1: register write-back strobe; `done & ~dst_port_q`.
- `io_direction` out `direction_t`: to `nodeio.direction`.
- `io_tx` out 1: to `nodeio.tx`.
- `io_rx` out 1: to `nodeio.rx`.
- `io_out_data` out `word_t`: to `nodeio.out_data`.
- `io_in_data` in `word_t`: from `nodeio.in_data`.
- `io_tx_complete` in 1: from `nodeio.tx_complete`.
- `io_rx_complete` in 1: from `nodeio.rx_complete`.
- `watchdog` out 1: present only with `MOVSEQ_WATCHDOG_EN`.

## Operation
- Registers, captured on an accepted start:
  - `src_dir_q`, `dst_dir_q`, `dst_port_q` are captured from the inputs.
  - `data_q` captures `src_value` when `src_port`=0.
  - Directions are held constant for the whole transfer, so they never track core inputs mid-transfer.
- States: IDLE, RX, TX, DONE (2-bit encoding).
- Transitions from IDLE on `start`:
  - `src_port`=1: go to RX.
  - `src_port`=0 and `dst_port`=1: go to TX.
  - Both 0: go to DONE (pass-through, `data_q`=`src_value`).
- In RX:
  - Drives `io_direction`=`src_dir_q`, `io_rx`=1.
  - On `io_rx_complete`, `data_q` takes `io_in_data`.
  - Next state is TX if `dst_port_q`, else DONE.
  - Without completion, RX holds.
- In TX:
  - Drives `io_direction`=`dst_dir_q`, `io_tx`=1, `io_out_data`=`data_q`.
  - On `io_tx_complete`, go to DONE; otherwise TX holds.
- In DONE: `done`=1, `result`=`data_q`, `result_we`=~`dst_port_q`, then go to IDLE unconditionally.
- `io_out_data`=`data_q` in all states.
- In IDLE/DONE: `io_tx`=`io_rx`=0, `io_direction`=UP.
- `io_tx` and `io_rx` are never high together.
- `busy` = `start` in IDLE, or state is RX/TX. `busy` is low in DONE, so the core advances on the `done` cycle.
- `start` while not IDLE is ignored and has no side effects.
- ANY/LAST are passed through unresolved; `nodeio` resolves them.
  - MOV ANY,LAST transmits to the port the value was just received from, because `nodeio` updates LAST on the RX completion cycle.
- Completion strobes arriving in a state that does not consume them are ignored.

## Timing
- Reset values:
  - State IDLE; `data_q`, `src_dir_q`, `dst_dir_q` = 0; `dst_port_q` = 0.
  - `busy`, `done`, `result_we`, `io_tx`, `io_rx`, `watchdog` = 0.
  - `result`, `io_out_data` = 0; `io_direction` = UP.
- Reset mid-transfer: the next state is IDLE, the pending handshake is dropped, and no `done` is generated.
- Minimum latencies, counted from the `start` cycle as cycle 0:
  - Register-to-register: `done` at cycle 1.
  - Transmit only: `io_tx` at cycle 1; with same-cycle `io_tx_complete`, `done` at cycle 2.
  - Receive only: `done` at cycle 2.
  - Port-to-port: RX cycle 1, TX cycle 2, `done` cycle 3.
- Each handshake stall adds one cycle per cycle the completion strobe is low.
- Completion is sampled combinationally from `nodeio` and acted on at the same posedge.
- Earliest next `start` is accepted in the IDLE cycle after DONE.

## Configuration
- `MOVSEQ_WATCHDOG_EN` defined:
  - An 11-bit saturating counter clears on every state change and increments each cycle spent in RX or TX.
  - When the count equals `WATCHDOG_CYCLES`, `watchdog` is set.
  - `watchdog` is sticky until the next accepted `start` or reset.
  - It is a debug flag only and never aborts the transfer, because blocking is legal behaviour.
- `MOVSEQ_WATCHDOG_EN` undefined: no counter and no `watchdog` port.
- Core behaviour is identical in both builds.

## Test plan
- MOV 42,ACC (`src_port`=0, `dst_port`=0, `src_value`=42):
  - `done`, `result_we`=1, `result`=42 at cycle 1.
  - `io_tx`/`io_rx` stay 0.
- MOV 7,RIGHT with `io_tx_complete` held low 3 cycles:
  - `io_tx`=1 and `io_direction`=RIGHT for 4 cycles, `io_out_data`=7.
  - `done` at cycle 5, `result_we`=0.
- MOV LEFT,ACC with `io_in_data`=-5 and completion at cycle 2:
  - `data_q`=-5; `done` at cycle 3 with `result`=-5, `result_we`=1.
  - `busy` high cycles 0–2.
- MOV UP,DOWN, value 999:
  - RX on UP, then TX on DOWN with `io_out_data`=999.
  - `io_rx`/`io_tx` never overlap; `done` once.
  - A second `start` pulsed during TX is ignored.
- Reset mid-TX (`nRST` low one cycle):
  - IDLE next cycle; all outputs at reset values; no `done`.
  - A following MOV 1,ACC completes normally.
- `MOVSEQ_WATCHDOG_EN`, `WATCHDOG_CYCLES`=8, RX never completes:
  - `watchdog` rises after 8 RX cycles, stays high.
  - Clears on the next accepted `start`.
